viterbi_dec: RTL and testbench



---
 rtl/viterbi_dec.sv | 186 ++++++++++++++++++
 tb/tb_viterbi_dec.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_dec.sv
// Hard-decision 4-state Viterbi decoder (K=3, rate 1/2), register-exchange survivors.
// Latency: p_depth accepted symbols plus one clock; the frame tail is flushed after i_last.
// Backpressure: o_ready drops for the flush cycles, and i_valid/i_last are ignored while it is low.
module viterbi_dec #(
  parameter logic [2:0] p_polinom_0    = 3'b111,
  parameter logic [2:0] p_polinom_1    = 3'b101,
  parameter int         p_depth        = 16,
  parameter int         p_metric_width = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_data,
  output logic       o_valid,
  output logic       o_last
);

  localparam int W  = p_metric_width;
  localparam int CW = $clog2(p_depth + 1);
  localparam int IW = $clog2(p_depth);
  localparam logic [W-1:0]  MMAX = '1;
  localparam logic [CW-1:0] LCNT = CW'(p_depth);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       metric_q [4];
  logic [W-1:0]       metric_d [4];
  logic [p_depth-1:0] surv_q [4];
  logic [p_depth-1:0] surv_d [4];
  logic               data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic [W-1:0]       cand_a [4];
  logic [W-1:0]       cand_b [4];
  logic [W-1:0]       acs_m [4];
  logic [W-1:0]       norm_m [4];
  logic [p_depth-1:0] acs_s [4];
  logic [W-1:0]       new_min;
  logic [W-1:0]       best_m;
  logic [1:0]         best;
  logic [CW-1:0]      cnt_m1;
  logic [CW-1:0]      cnt_p1;
  logic [IW-1:0]      fidx;
  logic               accept;

  // Hamming distance between the received symbol and the symbol expected on edge s --b-->
  function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic b,
                                               input logic [1:0] d);
    logic [2:0] w;
    logic [1:0] e;
    w    = {s, b};
    e[0] = ^(w & p_polinom_0);
    e[1] = ^(w & p_polinom_1);
    return {1'b0, d[0] ^ e[0]} + {1'b0, d[1] ^ e[1]};
  endfunction

  // Path metric plus branch metric, clamped at the all-ones value
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] m, input logic [1:0] b);
    logic [W:0] s;
    s = {1'b0, m} + {{(W-1){1'b0}}, b};
    return s[W] ? MMAX : s[W-1:0];
  endfunction

  // Add-compare-select for all four next states, then normalise against the new minimum
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cand_a[i] = sat_add(metric_q[{1'b0, i[1]}], branch_metric({1'b0, i[1]}, i[0], i_data));
      cand_b[i] = sat_add(metric_q[{1'b1, i[1]}], branch_metric({1'b1, i[1]}, i[0], i_data));
      // Ties go to the predecessor whose older bit is 0
      if (cand_b[i] < cand_a[i]) begin
        acs_m[i] = cand_b[i];
        acs_s[i] = {surv_q[{1'b1, i[1]}][p_depth-2:0], i[0]};
      end else begin
        acs_m[i] = cand_a[i];
        acs_s[i] = {surv_q[{1'b0, i[1]}][p_depth-2:0], i[0]};
      end
    end
    new_min = acs_m[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_m[i] < new_min) new_min = acs_m[i];
    end
    for (int i = 0; i < 4; i++) begin
      norm_m[i] = acs_m[i] - new_min;
    end
  end

  // Best state over the registered metrics, lowest index wins a tie
  always_comb begin
    best   = 2'd0;
    best_m = metric_q[0];
    for (int i = 1; i < 4; i++) begin
      if (metric_q[i] < best_m) begin
        best_m = metric_q[i];
        best   = 2'(i);
      end
    end
  end

  assign accept = i_valid && (state_q != FLUSH);
  assign cnt_m1 = cnt_q - CW'(1);
  assign cnt_p1 = cnt_q + CW'(1);
  assign fidx   = cnt_m1[IW-1:0];

  // Next-state logic: symbol intake in FILL/RUN, tail readout and reinit in FLUSH
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    metric_d = metric_q;
    surv_d   = surv_q;
    data_d   = 1'b0;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    case (state_q)
      FILL, RUN: begin
        if (accept) begin
          metric_d = norm_m;
          surv_d   = acs_s;
          if (state_q == RUN) begin
            data_d  = surv_q[best][p_depth-1];
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_p1;
          end
          if (i_last) begin
            state_d = FLUSH;
          end else if (state_q == FILL && cnt_p1 == LCNT) begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        // cnt doubles as the readout index, counting down to bit 0
        data_d  = surv_q[best][fidx];
        valid_d = 1'b1;
        cnt_d   = cnt_m1;
        if (cnt_q == CW'(1)) begin
          last_d  = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
          for (int i = 0; i < 4; i++) begin
            metric_d[i] = (i == 0) ? '0 : MMAX;
            surv_d[i]   = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, trellis and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        metric_q[i] <= (i == 0) ? '0 : MMAX;
        surv_q[i]   <= '0;
      end
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        metric_q[i] <= metric_d[i];
        surv_q[i]   <= surv_d[i];
      end
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_ready = (state_q != FLUSH);
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_viterbi_dec.sv
// Bench for viterbi_dec: encoder model feeds frames, a scoreboard compares decoded bits to the source.
// Timing model tracks expected o_valid/o_ready per cycle from accepted-symbol counts.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_viterbi_dec;

  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b00;
  logic       vin = 1'b0;
  logic       lin = 1'b0;
  logic       o_ready, o_data, o_valid, o_last;

  viterbi_dec dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_data  (din),
    .i_valid (vin),
    .i_last  (lin),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic l;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  // timing model state
  int   n_acc     = 0;
  int   flush_rem = 0;
  int   flush_dly = 0;
  int   rdy_low   = 0;
  bit   run_pipe  = 1'b0;
  bit   ev, er;
  ent_t ent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare outputs against the timing model and the scoreboard, then advance the model
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      ev = run_pipe || (flush_rem > 0 && flush_dly == 0);
      er = (rdy_low == 0);
      chk("o_valid", 32'(o_valid), 32'(ev));
      chk("o_ready", 32'(o_ready), 32'(er));
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got o_valid=1 expected no pending bit (cycle %0d)", cyc);
        end else begin
          ent = sb.pop_front();
          chk("o_data", 32'(o_data), 32'(ent.d));
          chk("o_last", 32'(o_last), 32'(ent.l));
        end
      end else begin
        chk("o_last_idle", 32'(o_last), 32'd0);
      end
      run_pipe = 1'b0;
      if (flush_rem > 0) begin
        if (flush_dly > 0) flush_dly--;
        else flush_rem--;
      end
      if (rdy_low > 0) rdy_low--;
      if (rst) begin
        n_acc     = 0;
        flush_rem = 0;
        flush_dly = 0;
        rdy_low   = 0;
      end else if (vin && er) begin
        run_pipe = (n_acc >= L);
        n_acc++;
        if (lin) begin
          flush_rem = (n_acc < L) ? n_acc : L;
          flush_dly = 1;
          rdy_low   = flush_rem;
          n_acc     = 0;
        end
      end
    end
  end

  // Encode and drive one frame; pushes every source bit to the scoreboard when it is accepted
  task automatic send_frame(input int nbits, input int tail, input int err_sym, input int gap_pct,
                            input bit junk, input bit use_pat, input logic [63:0] pat,
                            input bit no_last);
    logic [1:0] s;
    logic [2:0] w;
    logic [1:0] sym;
    logic       b;
    logic       is_last;
    int         total;
    int         wait_c;
    s     = 2'b00;
    total = nbits + tail;
    for (int k = 0; k < total; k++) begin
      if (k < nbits) b = use_pat ? pat[k] : 1'($urandom_range(0, 1));
      else b = 1'b0;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        vin = 1'b0;
        lin = 1'b0;
        @(posedge clk); #1;
      end
      wait_c = 0;
      while (o_ready !== 1'b1) begin
        if (junk) begin
          vin = 1'b1;
          din = 2'($urandom);
          lin = 1'($urandom);
        end else begin
          vin = 1'b0;
          lin = 1'b0;
        end
        @(posedge clk); #1;
        wait_c++;
        if (wait_c > 100) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout: got o_ready=0 for %0d cycles expected 1", wait_c);
          break;
        end
      end
      w      = {s, b};
      sym[0] = ^(w & 3'b111);
      sym[1] = ^(w & 3'b101);
      s      = {s[0], b};
      if (k == err_sym) sym[0] = ~sym[0];
      is_last = !no_last && (k == total - 1);
      din = sym;
      vin = 1'b1;
      lin = is_last;
      ent.d = b;
      ent.l = is_last;
      sb.push_back(ent);
      @(posedge clk); #1;
    end
    vin = 1'b0;
    lin = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog");
  end

  int drain;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    mon_en = 1'b1;

    // short error-free frame: bits 1,0,1,1 -> symbols 11,01,00,10
    send_frame(4, 0, -1, 0, 1'b0, 1'b1, 64'hD, 1'b0);
    // long error-free frame with zero tail
    send_frame(64, 2, -1, 0, 1'b0, 1'b0, 64'h0, 1'b0);
    // single channel error on bit 0 of symbol 20
    send_frame(64, 2, 20, 0, 1'b0, 1'b0, 64'h0, 1'b0);
    // new symbols offered during the previous flush must be ignored
    send_frame(24, 2, -1, 0, 1'b1, 1'b0, 64'h0, 1'b0);

    // partial frame discarded by a mid-frame reset
    send_frame(10, 0, -1, 0, 1'b0, 1'b0, 64'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_reset_state("midreset");
    send_frame(4, 0, -1, 0, 1'b0, 1'b1, 64'hD, 1'b0);

    // gapped input
    send_frame(64, 2, -1, 30, 1'b0, 1'b0, 64'h0, 1'b0);
    // random lengths around the decision depth, random bubbles, no tail
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(1, 40), 0, -1, $urandom_range(0, 40), 1'($urandom), 1'b0,
                 64'h0, 1'b0);
    end

    drain = 0;
    while (sb.size() != 0 && drain < 300) begin
      @(posedge clk); #1;
      drain++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
